// File: rtl/alu_seq_if.sv
// ALU request/response channel bundle: operand request (valid/ready) and
// result response (valid/ready). master = requester, slave = ALU responder.
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_Sel;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] ALU_Out;
    logic             CarryOut;

    modport master (
        output req_valid, A, B, ALU_Sel, rsp_ready,
        input  req_ready, rsp_valid, ALU_Out, CarryOut
    );

    modport slave (
        input  req_valid, A, B, ALU_Sel, rsp_ready,
        output req_ready, rsp_valid, ALU_Out, CarryOut
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential handshaked ALU responder; MUL (shift-add) and DIV (restoring)
// iterate WIDTH cycles, all other ops answer one cycle after acceptance.
// Ports: clk, rst (sync, active-high), bus (alu_seq_if.slave: req_valid,
//   req_ready, A, B, ALU_Sel, rsp_valid, rsp_ready, ALU_Out, CarryOut).
// Option: define ALU_SEQ_FAST_MUL_EN for a combinational single-cycle MUL.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, RESP = 2'd2} state_e;

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               cy_q, cy_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcd_q, mcd_d;
    // MUL: multiplier shifted right; DIV: dividend shifting into quotient
    logic [WIDTH-1:0]   mpl_q, mpl_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               div_q, div_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH:0]     sum, dif;
    logic [WIDTH-1:0]   sc_out;
    logic               sc_cy;
    logic               iter_op;

    assign sum = {1'b0, bus.A} + {1'b0, bus.B};
    assign dif = {1'b0, bus.A} - {1'b0, bus.B};

`ifdef ALU_SEQ_FAST_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod    = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
    assign iter_op = (bus.ALU_Sel == 4'd3) && (bus.B != '0);
`else
    assign iter_op = (bus.ALU_Sel == 4'd2) ||
                     ((bus.ALU_Sel == 4'd3) && (bus.B != '0));
`endif

    // Single-cycle result, computed from the request as it is accepted
    always_comb begin
        sc_out = '0;
        sc_cy  = 1'b0;
        unique case (bus.ALU_Sel)
            4'd0: {sc_cy, sc_out} = sum;
            4'd1: {sc_cy, sc_out} = dif;
`ifdef ALU_SEQ_FAST_MUL_EN
            4'd2: begin
                sc_out = prod[WIDTH-1:0];
                sc_cy  = |prod[2*WIDTH-1:WIDTH];
            end
`else
            4'd2: sc_out = '0;
`endif
            // reached only for B==0; nonzero divisors iterate
            4'd3: begin
                sc_out = '1;
                sc_cy  = 1'b1;
            end
            4'd4:  {sc_cy, sc_out} = {bus.A, 1'b0};
            4'd5:  {sc_out, sc_cy} = {1'b0, bus.A};
            4'd6:  sc_out = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
            4'd7:  sc_out = {bus.A[0], bus.A[WIDTH-1:1]};
            4'd8:  sc_out = bus.A & bus.B;
            4'd9:  sc_out = bus.A | bus.B;
            4'd10: sc_out = bus.A ^ bus.B;
            4'd11: sc_out = ~(bus.A | bus.B);
            4'd12: sc_out = ~(bus.A & bus.B);
            4'd13: sc_out = ~(bus.A ^ bus.B);
            4'd14: sc_out = {{(WIDTH-1){1'b0}}, bus.A > bus.B};
            4'd15: sc_out = {{(WIDTH-1){1'b0}}, bus.A == bus.B};
        endcase
    end

    // One iteration step of either algorithm
    logic [2*WIDTH-1:0] acc_n;
    logic [WIDTH:0]     trial;
    logic               ge;
    logic [WIDTH-1:0]   rem_n, quo_n;

    assign acc_n = mpl_q[0] ? acc_q + mcd_q : acc_q;
    // trial subtract: bit WIDTH set means partial remainder < divisor
    assign trial = {rem_q, mpl_q[WIDTH-1]} - {1'b0, dvs_q};
    assign ge    = ~trial[WIDTH];
    assign rem_n = ge ? trial[WIDTH-1:0]
                      : {rem_q[WIDTH-2:0], mpl_q[WIDTH-1]};
    assign quo_n = {mpl_q[WIDTH-2:0], ge};

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cy_d    = cy_q;
        acc_d   = acc_q;
        mcd_d   = mcd_q;
        mpl_d   = mpl_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (iter_op) begin
                        state_d = ITER;
                        div_d   = (bus.ALU_Sel == 4'd3);
                        cnt_d   = '0;
                        acc_d   = '0;
                        mcd_d   = {{WIDTH{1'b0}}, bus.A};
                        mpl_d   = (bus.ALU_Sel == 4'd3) ? bus.A : bus.B;
                        rem_d   = '0;
                        dvs_d   = bus.B;
                    end else begin
                        state_d = RESP;
                        out_d   = sc_out;
                        cy_d    = sc_cy;
                    end
                end
            end
            ITER: begin
                cnt_d = cnt_q + CW'(1);
                if (div_q) begin
                    rem_d = rem_n;
                    mpl_d = quo_n;
                end else begin
                    acc_d = acc_n;
                    mcd_d = mcd_q << 1;
                    mpl_d = mpl_q >> 1;
                end
                if (cnt_q == LAST) begin
                    state_d = RESP;
                    out_d   = div_q ? quo_n : acc_n[WIDTH-1:0];
                    cy_d    = div_q ? 1'b0 : |acc_n[2*WIDTH-1:WIDTH];
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            cy_q    <= 1'b0;
            acc_q   <= '0;
            mcd_q   <= '0;
            mpl_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            div_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cy_q    <= cy_d;
            acc_q   <= acc_d;
            mcd_q   <= mcd_d;
            mpl_q   <= mpl_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.ALU_Out   = out_q;
    assign bus.CarryOut  = cy_q;
endmodule
